// File: rtl/ex_wb_pkg.sv
// Shared definitions for the EX/WB stage: opcodes, instruction field slices, ID/EX record.
// Build option: EX_FWD_EN enables write-back-to-operand forwarding in ex_wb_stage.
package ex_wb_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_SUBI = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 3;
    localparam int IMM_HI = 2;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic       valid;
        logic [1:0] op;
        logic [2:0] rs;
        logic [2:0] rd;
        logic [7:0] rdata;
        logic [7:0] imm;
    } id_ex_t;

    // MOV writes the register named by the immediate field; arithmetic ops write back to rs.
    function automatic logic [2:0] dest_reg(input logic [7:0] instr);
        logic [2:0] rd_v;
        case (instr[OP_HI:OP_LO])
            OP_MOV:  rd_v = instr[IMM_HI:IMM_LO];
            OP_ADDI: rd_v = instr[RS_HI:RS_LO];
            OP_SUBI: rd_v = instr[RS_HI:RS_LO];
            default: rd_v = 3'd0;
        endcase
        return rd_v;
    endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// Bus between the decode/register-file side and the EX/WB stage.
interface ex_wb_stage_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       Instr_Code;
    logic [7:0]       Read_Data;
    logic [7:0]       Imm_Extend;
    logic             Stall;
    logic             Flush;
    logic [2:0]       ID_EX_RD;
    logic [2:0]       EX_WB_RD;
    logic [7:0]       EX_WB_Write_Data;
    logic             EX_WB_Reg_Write;
    logic [CNT_W-1:0] Retired_Count;

    modport master (
        output Instr_Code, Read_Data, Imm_Extend, Stall, Flush,
        input  ID_EX_RD, EX_WB_RD, EX_WB_Write_Data, EX_WB_Reg_Write, Retired_Count
    );

    modport slave (
        input  Instr_Code, Read_Data, Imm_Extend, Stall, Flush,
        output ID_EX_RD, EX_WB_RD, EX_WB_Write_Data, EX_WB_Reg_Write, Retired_Count
    );
endinterface

// File: rtl/ex_alu.sv
// Combinational 8-bit ALU for the execute stage; results wrap modulo 256.
import ex_wb_pkg::*;

module ex_alu (
    input  logic [1:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_imm,
    output logic [7:0] o_result
);

    // Opcode-selected result; NOP produces zero.
    always_comb begin
        o_result = 8'h00;
        case (i_op)
            OP_MOV:  o_result = i_a;
            OP_ADDI: o_result = i_a + i_imm;
            OP_SUBI: o_result = i_a - i_imm;
            default: o_result = 8'h00;
        endcase
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage: ID/EX register, ALU and EX/WB write-back register with retire counter.
// Define EX_FWD_EN to forward the pending write-back into operand A.
import ex_wb_pkg::*;

module ex_wb_stage #(
    parameter int CNT_W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    ex_wb_stage_if.slave bus
);

    id_ex_t           r_id_ex;
    logic [2:0]       r_wb_rd;
    logic [7:0]       r_wb_data;
    logic             r_wb_we;
    logic [CNT_W-1:0] r_count;

    logic [7:0]       w_op_a;
    logic [7:0]       w_alu;
    logic             w_retire;

`ifdef EX_FWD_EN
    // Bypass the value being written back when it targets this instruction's source.
    always_comb begin
        w_op_a = r_id_ex.rdata;
        if (r_wb_we && (r_wb_rd == r_id_ex.rs)) begin
            w_op_a = r_wb_data;
        end else begin
            w_op_a = r_id_ex.rdata;
        end
    end
`else
    assign w_op_a = r_id_ex.rdata;
`endif

    ex_alu u_alu (
        .i_op     (r_id_ex.op),
        .i_a      (w_op_a),
        .i_imm    (r_id_ex.imm),
        .o_result (w_alu)
    );

    // A flush kills the instruction sitting in ID/EX before it can reach write-back.
    assign w_retire = r_id_ex.valid & ~bus.Flush & ~bus.Stall;

    // ID/EX pipeline register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_id_ex <= '0;
        end else if (bus.Flush) begin
            r_id_ex.valid <= 1'b0;
            r_id_ex.rd    <= 3'd0;
        end else if (bus.Stall) begin
            r_id_ex <= r_id_ex;
        end else begin
            r_id_ex.valid <= (bus.Instr_Code[OP_HI:OP_LO] != OP_NOP);
            r_id_ex.op    <= bus.Instr_Code[OP_HI:OP_LO];
            r_id_ex.rs    <= bus.Instr_Code[RS_HI:RS_LO];
            r_id_ex.rd    <= dest_reg(bus.Instr_Code);
            r_id_ex.rdata <= bus.Read_Data;
            r_id_ex.imm   <= bus.Imm_Extend;
        end
    end

    // EX/WB register; a stall inserts a bubble while holding destination and data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wb_we   <= 1'b0;
            r_wb_rd   <= 3'd0;
            r_wb_data <= 8'h00;
        end else if (bus.Stall) begin
            r_wb_we   <= 1'b0;
        end else begin
            r_wb_we   <= w_retire;
            r_wb_rd   <= r_id_ex.rd;
            r_wb_data <= w_alu;
        end
    end

    // Retired write-back counter, wraps silently.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign bus.ID_EX_RD         = r_id_ex.rd;
    assign bus.EX_WB_RD         = r_wb_rd;
    assign bus.EX_WB_Write_Data = r_wb_data;
    assign bus.EX_WB_Reg_Write  = r_wb_we;
    assign bus.Retired_Count    = r_count;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage; a narrow counter exercises wrap-around.
module tb_ex_wb_stage;

    localparam int TB_CNT_W = 2;

    typedef struct {
        int                  cyc;
        logic [2:0]          rd;
        logic [7:0]          data;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t q[$];
    logic [TB_CNT_W-1:0] exp_cnt;

    ex_wb_stage_if #(.CNT_W(TB_CNT_W)) bus ();

    ex_wb_stage #(.CNT_W(TB_CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] sext3(input logic [2:0] v);
        return {{5{v[2]}}, v};
    endfunction

    task automatic drive(input logic [7:0] ins, input logic [7:0] rdat, input logic st, input logic fl);
        @(negedge Clk);
        bus.Instr_Code = ins;
        bus.Read_Data  = rdat;
        bus.Imm_Extend = sext3(ins[2:0]);
        bus.Stall      = st;
        bus.Flush      = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_wb(input logic [2:0] rd, input logic [7:0] data, input int dly);
        exp_t e;
        exp_cnt = exp_cnt + 2'd1;
        e.cyc  = cyc + dly;
        e.rd   = rd;
        e.data = data;
        e.cnt  = exp_cnt;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset          = 1'b1;
        bus.Instr_Code = 8'h00;
        bus.Read_Data  = 8'h00;
        bus.Imm_Extend = 8'h00;
        bus.Stall      = 1'b0;
        bus.Flush      = 1'b0;
        @(negedge Clk);
        chk("rst_id_ex_rd", 32'(bus.ID_EX_RD), 32'd0);
        chk("rst_wb_rd", 32'(bus.EX_WB_RD), 32'd0);
        chk("rst_wb_data", 32'(bus.EX_WB_Write_Data), 32'd0);
        chk("rst_wb_we", 32'(bus.EX_WB_Reg_Write), 32'd0);
        chk("rst_count", 32'(bus.Retired_Count), 32'd0);
        Reset   = 1'b0;
        exp_cnt = '0;
    endtask

    // Monitor: every write-back pulse must match the oldest pending expectation.
    always @(negedge Clk) begin
        if (!Reset && bus.EX_WB_Reg_Write === 1'b1) begin
            if (q.size() == 0) begin
                chk("wb_pending", 32'(q.size()), 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
                chk("wb_rd", 32'(bus.EX_WB_RD), 32'(e.rd));
                chk("wb_data", 32'(bus.EX_WB_Write_Data), 32'(e.data));
                chk("wb_count", 32'(bus.Retired_Count), 32'(e.cnt));
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        exp_cnt        = '0;
        Reset          = 1'b1;
        bus.Instr_Code = 8'h00;
        bus.Read_Data  = 8'h00;
        bus.Imm_Extend = 8'h00;
        bus.Stall      = 1'b0;
        bus.Flush      = 1'b0;
        do_reset();

        // ADDI r3,+2 with R3=3
        drive(8'b10_011_010, 8'd3, 1'b0, 1'b0);
        expect_wb(3'd3, 8'd5, 2);
        idle(3);

        // back-to-back dependency on r3, second operand stale
        drive(8'b10_011_010, 8'd3, 1'b0, 1'b0);
        expect_wb(3'd3, 8'd5, 2);
        drive(8'b10_011_001, 8'd3, 1'b0, 1'b0);
`ifdef EX_FWD_EN
        expect_wb(3'd3, 8'd6, 2);
`else
        expect_wb(3'd3, 8'd4, 2);
`endif
        idle(3);

        // one-cycle stall with ADDI in ID/EX; fourth write wraps the counter to 0
        drive(8'b10_011_010, 8'd3, 1'b0, 1'b0);
        expect_wb(3'd3, 8'd5, 3);
        drive(8'h00, 8'h00, 1'b1, 1'b0);
        idle(3);

        // flush with ADDI in ID/EX, then NOPs: nothing may retire
        drive(8'b10_011_010, 8'd3, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b1);
        chk("id_ex_rd_addi", 32'(bus.ID_EX_RD), 32'd3);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        chk("id_ex_rd_flushed", 32'(bus.ID_EX_RD), 32'd0);
        drive(8'h07, 8'h33, 1'b0, 1'b0);
        idle(3);
        chk("count_after_flush_nop", 32'(bus.Retired_Count), 32'(exp_cnt));

        // SUBI r0,+1 with R0=0 underflows
        drive(8'b11_000_001, 8'h00, 1'b0, 1'b0);
        expect_wb(3'd0, 8'hFF, 2);
        idle(3);

        // MOV r5 <= r2
        drive(8'b01_010_101, 8'h5A, 1'b0, 1'b0);
        expect_wb(3'd5, 8'h5A, 2);
        idle(3);

        // ADDI r1,-1 with R1=0x10
        drive(8'b10_001_111, 8'h10, 1'b0, 1'b0);
        expect_wb(3'd1, 8'h0F, 2);
        idle(3);

        // reset mid-run clears the counter and outputs
        do_reset();
        drive(8'b11_100_010, 8'h01, 1'b0, 1'b0);
        expect_wb(3'd4, 8'hFF, 2);
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
